regfile_wr_serializer: RTL and testbench
========================================

# regfile_wr_serializer

Write-side front end for the 3-read/1-write 32-deep distributed register-file RAM. It accepts up to two architectural writes per cycle from the two commit lanes and buffers them in a small in-order queue. It drains the queue through the RAM's single write port at one write per cycle. It also exposes a pending-write lookup so issue logic can forward data that is queued but not yet written.

## Interface
- WIDTH, 32, data width of one register; must match the RAM's WIDTH.
- DEPTH, 4, queue entries; power of two, at least 2.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w0_valid  in  1  lane 0 write request; lane 0 is older than lane 1.
- w0_addr  in  5  lane 0 destination register.
- w0_data  in  WIDTH  lane 0 write data.
- w1_valid  in  1  lane 1 write request.
- w1_addr  in  5  lane 1 destination register.
- w1_data  in  WIDTH  lane 1 write data.
- in_ready  out  1  queue can take two writes this cycle.
- addrw  out  5  RAM write address.
- din  out  WIDTH  RAM write data.
- wea  out  1  RAM write enable.
- pend_addr  in  5  lookup address from issue.
- pend_hit  out  1  a queued write to pend_addr exists.
- pend_data  out  WIDTH  data of the youngest queued write to pend_addr.
- count  out  $clog2(DEPTH)+1  occupied entries (registered).

## Operation
- Queue: circular buffer with head and tail pointers, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH, plus a registered count.
- Accept: writes are taken only when in_ready=1. Valid requests while in_ready=0 are ignored, and upstream must hold them.
- in_ready = (DEPTH − count) ≥ 2. It uses the registered count only; the same-cycle pop is not credited.
- Filtering, applied before enqueue:
  - A write with addr 0 is discarded, because r0 is hardwired zero.
  - If both lanes are valid with equal nonzero addresses, lane 0 is squashed and only lane 1 is enqueued.
- Enqueue order: lane 0 at tail, then lane 1 at tail+1. If only one lane survives filtering, it takes tail.
- Drain: when count≠0, the head entry drives addrw/din with wea=1. That entry is popped at the same edge, because the RAM always accepts a write.
- Count update: count_next = count + pushes − pop. The pushes term is 0..2 and the pop term is 0..1. Simultaneous push 2 / pop 1 gives a net +1.
- Lookup:
  - pend_hit/pend_data are combinational over valid entries only, from head to tail−1.
  - When several entries match, the youngest wins.
  - pend_addr=0 always gives pend_hit=0.
  - Writes arriving in the current cycle are not visible to the lookup.
- When count=0 (and no bypass fires): wea=0, and addrw/din are don't-care but held at the head entry contents.
- Reset:
  - head=tail=0, count=0.
  - wea=0, in_ready=1, pend_hit=0.
  - Queued writes are dropped; requests presented in the reset cycle are ignored.

## Timing
- Write accepted at edge N appears on wea/addrw/din in cycle N+1 at the earliest. It reaches the RAM array at edge N+1+k, where k is the number of older queued entries.
- Throughput: sustained one RAM write per cycle. Two-per-cycle input is accepted only while the queue has room.
- Lookup path: combinational pend_addr → pend_hit/pend_data within the same cycle.
- Order is preserved: writes to the same address commit to the RAM in program order.

## Configuration
- REGFILE_WR_BYPASS_EN defined:
  - Condition: count=0, in_ready=1, and the first surviving write after filtering is present (lane 0, or lane 1 if lane 0 was filtered).
  - That write drives addrw/din/wea combinationally in the same cycle and is not enqueued.
  - A second surviving write, if present, is enqueued at tail.
  - Latency is 0 cycles to the write port.
  - pend_hit does not report the bypassed write, because the RAM holds it from the next cycle.
- Not defined: every write goes through the queue; minimum latency is 1 cycle; wea depends on registered state only.

## Test plan
- Reset: assert rst for 2 cycles with w0_valid=1 → count=0, wea=0, in_ready=1 after release; no RAM write occurs.
- Single write: w0 addr 5 data 0xDEADBEEF for one cycle → next cycle wea=1, addrw=5, din=0xDEADBEEF. The cycle after, wea=0. With bypass: wea=1 in the same cycle.
- Dual write, same address: w0 (3, 0x11), w1 (3, 0x22) → exactly one RAM write, (3, 0x22).
- r0 filter: w0 (0, 0xFFFF), w1 (7, 0x33) → only (7, 0x33) is written, and count never exceeds 1.
- Backpressure and wrap: DEPTH=4, present dual writes every cycle for 6 cycles.
  - Required: in_ready drops to 0 when count=3, then cycles between 1 and 0 as entries drain.
  - Required: all accepted writes come out in order across pointer wrap, with no loss or duplication.
- Lookup: queue holds (9, 0xA) then (9, 0xB), pend_addr=9 → pend_hit=1, pend_data=0xB. After both drain, pend_hit=0.

Source files
------------

// File: rtl/regfile_wr_serializer.sv
// Two-lane commit write queue feeding the single write port of the register-file RAM.
// Optional same-cycle write-port bypass when the queue is empty: define REGFILE_WR_BYPASS_EN.
module regfile_wr_serializer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w0_valid,
    input  logic [4:0]               w0_addr,
    input  logic [WIDTH-1:0]         w0_data,
    input  logic                     w1_valid,
    input  logic [4:0]               w1_addr,
    input  logic [WIDTH-1:0]         w1_data,
    output logic                     in_ready,
    output logic [4:0]               addrw,
    output logic [WIDTH-1:0]         din,
    output logic                     wea,
    input  logic [4:0]               pend_addr,
    output logic                     pend_hit,
    output logic [WIDTH-1:0]         pend_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];

    logic             w_ready;
    logic             w_acc;
    logic             w_v0;
    logic             w_v1;
    logic             w_byp;
    logic             w_pop;
    logic             w_sa_vld;
    logic [4:0]       w_sa_addr;
    logic [WIDTH-1:0] w_sa_data;
    logic             w_sb_vld;
    logic [4:0]       w_out_addr;
    logic [WIDTH-1:0] w_out_data;
    logic [CNT_W-1:0] w_pushes;
    logic [PTR_W-1:0] w_lk_idx;

    // Readiness ignores the same-cycle pop so it stays a pure register decode.
    assign w_ready = (r_count <= READY_LIM);
    assign w_acc   = w_ready && !rst;

    // r0 writes vanish; lane 0 is squashed when lane 1 overwrites the same register.
    assign w_v0 = w0_valid && (w0_addr != 5'd0) && !(w1_valid && (w1_addr == w0_addr));
    assign w_v1 = w1_valid && (w1_addr != 5'd0);

`ifdef REGFILE_WR_BYPASS_EN
    assign w_byp = w_acc && (r_count == '0) && (w_v0 || w_v1);
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
        w_sa_vld   = 1'b0;
        w_sa_addr  = w0_addr;
        w_sa_data  = w0_data;
        w_sb_vld   = 1'b0;
        w_out_addr = r_addr[r_head];
        w_out_data = r_data[r_head];
        if (w_byp) begin
            if (w_v0) begin
                w_out_addr = w0_addr;
                w_out_data = w0_data;
                if (w_v1) begin
                    w_sa_vld  = 1'b1;
                    w_sa_addr = w1_addr;
                    w_sa_data = w1_data;
                end
            end else begin
                w_out_addr = w1_addr;
                w_out_data = w1_data;
            end
        end else if (w_acc) begin
            if (w_v0) begin
                w_sa_vld = 1'b1;
                w_sb_vld = w_v1;
            end else if (w_v1) begin
                w_sa_vld  = 1'b1;
                w_sa_addr = w1_addr;
                w_sa_data = w1_data;
            end
        end
    end

    assign w_pop    = (r_count != '0) && !rst;
    assign w_pushes = CNT_W'(w_sa_vld) + CNT_W'(w_sb_vld);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_tail  <= r_tail + w_pushes[PTR_W-1:0];
            r_count <= r_count + w_pushes - CNT_W'(w_pop);
        end
    end

    // Slot B is always lane 1 at tail+1; it is only used when both lanes survive.
    always_ff @(posedge clk) begin
        if (w_sa_vld) begin
            r_addr[r_tail] <= w_sa_addr;
            r_data[r_tail] <= w_sa_data;
        end
        if (w_sb_vld) begin
            r_addr[r_tail + PTR_W'(1)] <= w1_addr;
            r_data[r_tail + PTR_W'(1)] <= w1_data;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        pend_hit  = 1'b0;
        pend_data = '0;
        w_lk_idx  = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_lk_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (pend_addr != 5'd0) && (r_addr[w_lk_idx] == pend_addr)) begin
                pend_hit  = 1'b1;
                pend_data = r_data[w_lk_idx];
            end
        end
    end

    assign in_ready = w_ready;
    assign wea      = w_pop || w_byp;
    assign addrw    = w_out_addr;
    assign din      = w_out_data;
    assign count    = r_count;

endmodule

// File: tb/tb_regfile_wr_serializer.sv
// Directed bench for regfile_wr_serializer in its default (queued, no bypass) build.
module tb_regfile_wr_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        w0_valid;
    logic [4:0]  w0_addr;
    logic [31:0] w0_data;
    logic        w1_valid;
    logic [4:0]  w1_addr;
    logic [31:0] w1_data;
    logic        in_ready;
    logic [4:0]  addrw;
    logic [31:0] din;
    logic        wea;
    logic [4:0]  pend_addr;
    logic        pend_hit;
    logic [31:0] pend_data;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]  obs_addr[$];
    logic [31:0] obs_data[$];

    regfile_wr_serializer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data),
        .in_ready(in_ready), .addrw(addrw), .din(din), .wea(wea),
        .pend_addr(pend_addr), .pend_hit(pend_hit), .pend_data(pend_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_lanes();
        w0_valid = 1'b0;
        w1_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        static logic [0:5] exp_rdy = 6'b110101;
        static int         exp_cnt[6] = '{0, 2, 3, 2, 3, 2};
        int pair;
        logic acc;

        rst = 1'b1;
        w0_valid = 1'b1; w0_addr = 5'd5; w0_data = 32'h12345678;
        w1_valid = 1'b0; w1_addr = 5'd0; w1_data = 32'h0;
        pend_addr = 5'd0;

        // reset with a request held
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        rst = 1'b0;
        idle_lanes();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_hit", 32'(pend_hit), 32'd0);
        tick();
        chk("post_rst_wea", 32'(wea), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);

        // single write
        w0_valid = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEADBEEF;
        chk("single_same_cycle_wea", 32'(wea), 32'd0);
        tick();
        idle_lanes();
        chk("single_wea", 32'(wea), 32'd1);
        chk("single_addr", 32'(addrw), 32'd5);
        chk("single_din", din, 32'hDEADBEEF);
        chk("single_count", 32'(count), 32'd1);
        tick();
        chk("single_wea_off", 32'(wea), 32'd0);
        chk("single_count0", 32'(count), 32'd0);

        // dual write same address
        w0_valid = 1'b1; w0_addr = 5'd3; w0_data = 32'h11;
        w1_valid = 1'b1; w1_addr = 5'd3; w1_data = 32'h22;
        tick();
        idle_lanes();
        chk("same_count", 32'(count), 32'd1);
        chk("same_wea", 32'(wea), 32'd1);
        chk("same_addr", 32'(addrw), 32'd3);
        chk("same_din", din, 32'h22);
        tick();
        chk("same_wea_off", 32'(wea), 32'd0);
        chk("same_count0", 32'(count), 32'd0);

        // r0 filter
        w0_valid = 1'b1; w0_addr = 5'd0; w0_data = 32'hFFFF;
        w1_valid = 1'b1; w1_addr = 5'd7; w1_data = 32'h33;
        tick();
        idle_lanes();
        chk("r0_count", 32'(count), 32'd1);
        chk("r0_wea", 32'(wea), 32'd1);
        chk("r0_addr", 32'(addrw), 32'd7);
        chk("r0_din", din, 32'h33);
        tick();
        chk("r0_wea_off", 32'(wea), 32'd0);
        chk("r0_count0", 32'(count), 32'd0);

        // lookup: queue holds (9,A),(9,B),(2,2) after two dual pushes
        w0_valid = 1'b1; w0_addr = 5'd1; w0_data = 32'h1;
        w1_valid = 1'b1; w1_addr = 5'd9; w1_data = 32'hA;
        pend_addr = 5'd9;
        chk("lk_incoming_invisible", 32'(pend_hit), 32'd0);
        tick();
        w0_addr = 5'd9; w0_data = 32'hB;
        w1_addr = 5'd2; w1_data = 32'h2;
        chk("lk_one_hit", 32'(pend_hit), 32'd1);
        chk("lk_one_data", pend_data, 32'hA);
        tick();
        idle_lanes();
        chk("lk_count3", 32'(count), 32'd3);
        chk("lk_ready0", 32'(in_ready), 32'd0);
        chk("lk_hit", 32'(pend_hit), 32'd1);
        chk("lk_youngest", pend_data, 32'hB);
        pend_addr = 5'd2;
        #1;
        chk("lk_hit2", 32'(pend_hit), 32'd1);
        chk("lk_data2", pend_data, 32'h2);
        pend_addr = 5'd1;
        #1;
        chk("lk_popped_miss", 32'(pend_hit), 32'd0);
        pend_addr = 5'd0;
        #1;
        chk("lk_r0_miss", 32'(pend_hit), 32'd0);
        pend_addr = 5'd9;
        chk("lk_drain_addr", 32'(addrw), 32'd9);
        chk("lk_drain_din", din, 32'hA);
        tick();
        chk("lk_after_a_hit", 32'(pend_hit), 32'd1);
        chk("lk_after_a_data", pend_data, 32'hB);
        tick();
        chk("lk_after_b_hit", 32'(pend_hit), 32'd0);
        tick();
        chk("lk_empty_count", 32'(count), 32'd0);

        // backpressure and wrap: four pairs, addresses 8..15, held until accepted
        pair = 0;
        for (int c = 0; c < 6; c++) begin
            w0_valid = 1'b1; w0_addr = 5'(8 + 2 * pair); w0_data = 32'hC000 + 32'(8 + 2 * pair);
            w1_valid = 1'b1; w1_addr = 5'(9 + 2 * pair); w1_data = 32'hC000 + 32'(9 + 2 * pair);
            chk($sformatf("bp_ready_c%0d", c), 32'(in_ready), 32'(exp_rdy[c]));
            chk($sformatf("bp_count_c%0d", c), 32'(count), 32'(exp_cnt[c]));
            if (wea) begin
                obs_addr.push_back(addrw);
                obs_data.push_back(din);
            end
            acc = in_ready;
            tick();
            if (acc) pair++;
        end
        idle_lanes();
        chk("bp_count_end", 32'(count), 32'd3);
        for (int j = 0; j < 10; j++) begin
            if (wea) begin
                obs_addr.push_back(addrw);
                obs_data.push_back(din);
            end
            tick();
        end
        chk("bp_drained", 32'(count), 32'd0);
        chk("bp_num_writes", 32'(obs_addr.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_addr_%0d", k), (k < obs_addr.size()) ? 32'(obs_addr[k]) : 32'hFFFF_FFFF, 32'(8 + k));
            chk($sformatf("bp_data_%0d", k), (k < obs_data.size()) ? obs_data[k] : 32'hFFFF_FFFF, 32'hC000 + 32'(8 + k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
